// File: rtl/peak_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peak_scanner_pkg
// Description : Shared types and constants for the peak_scanner block.
//               State encoding of the scan FSM, scan mode encodings and a
//               helper that decodes the "scan in progress" states.
// Revision    : 1.0 - initial release
// ============================================================================
package peak_scanner_pkg;

    // Scan FSM states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH0  = 3'd1,
        INIT    = 3'd2,
        FETCH   = 3'd3,
        CMP     = 3'd4,
        DONE_ST = 3'd5,
        HOLD    = 3'd6
    } state_t;

    // Scan mode: peaks/maximum or valleys/minimum.
    localparam logic MODE_PEAK   = 1'b0;
    localparam logic MODE_VALLEY = 1'b1;

    // True while the FSM is actively walking the RAM.
    function automatic logic state_is_busy(input state_t s);
        return (s == FETCH0) || (s == INIT) || (s == FETCH) || (s == CMP);
    endfunction

endpackage : peak_scanner_pkg
`default_nettype wire

// File: rtl/peak_scanner_ram.sv
`default_nettype none
// ============================================================================
// Module      : sample_ram
// Description : DEPTH x DATA_W sample store. One synchronous write port and
//               one registered read port (1-cycle read latency). Contents are
//               not reset.
// Ports       : clk     - clock, rising edge
//               i_we    - write enable
//               i_waddr - write address
//               i_wdata - write data
//               i_raddr - read address
//               o_rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sample_ram #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem_q [DEPTH];
    logic [DATA_W-1:0] r_rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
        r_rdata_q <= r_mem_q[i_raddr];
    end

    assign o_rdata = r_rdata_q;

endmodule : sample_ram
`default_nettype wire

// File: rtl/peak_scanner.sv
`default_nettype none
// ============================================================================
// Module      : peak_scanner
// Description : Scans a loadable signed sample RAM once per START request,
//               counting local peaks (MODE=0) or valleys (MODE=1) and tracking
//               the running maximum / minimum. Results are held with a
//               START-release handshake.
// Ports       : CLOCK   - clock, rising edge
//               RESET   - synchronous active-high reset
//               START   - scan request level; held high to keep HOLD
//               MODE    - 0 peaks/max, 1 valleys/min (sampled with START)
//               WR_EN   - RAM write strobe (ignored while BUSY)
//               WR_ADDR - RAM write address
//               WR_DATA - signed RAM write data
//               BUSY    - scan in progress
//               DONE    - results valid
//               EXTREME - signed running max / min
//               SIGN    - EXTREME is negative
//               COUNT   - number of peaks / valleys found
// Revision    : 1.0 - initial release
// ============================================================================
module peak_scanner
    import peak_scanner_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 5
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              START,
    input  logic              MODE,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] EXTREME,
    output logic              SIGN,
    output logic [ADDR_W-1:0] COUNT
);

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t                    r_state_q,   w_state_d;
    logic                      r_mode_q,    w_mode_d;
    logic                      r_flag_q,    w_flag_d;
    logic                      r_done_q,    w_done_d;
    logic [ADDR_W-1:0]         r_mar_q,     w_mar_d;
    logic [ADDR_W-1:0]         r_count_q,   w_count_d;
    logic signed [DATA_W-1:0]  r_temp_q,    w_temp_d;
    logic signed [DATA_W-1:0]  r_extreme_q, w_extreme_d;

    logic                      w_ram_we;
    logic signed [DATA_W-1:0]  w_rdata;
    logic [DATA_W:0]           w_diff;
    logic                      w_diff_neg;
    logic                      w_diff_pos;

    // Writes are only allowed while the FSM is not walking the RAM.
    assign w_ram_we = WR_EN && ((r_state_q == IDLE) || (r_state_q == HOLD));

    // MAR is 0 in FETCH0 and the sample index in FETCH, so it drives the read
    // address directly; data arrives in the following INIT/CMP state.
    sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_sample_ram (
        .clk     (CLOCK),
        .i_we    (w_ram_we),
        .i_waddr (WR_ADDR),
        .i_wdata (WR_DATA),
        .i_raddr (r_mar_q),
        .o_rdata (w_rdata)
    );

    // One extra bit so rdata - TEMP can never overflow.
    assign w_diff     = {w_rdata[DATA_W-1], w_rdata} - {r_temp_q[DATA_W-1], r_temp_q};
    assign w_diff_neg = w_diff[DATA_W];
    assign w_diff_pos = !w_diff[DATA_W] && (w_diff != '0);

    always_comb begin
        w_state_d   = r_state_q;
        w_mode_d    = r_mode_q;
        w_flag_d    = r_flag_q;
        w_done_d    = r_done_q;
        w_mar_d     = r_mar_q;
        w_count_d   = r_count_q;
        w_temp_d    = r_temp_q;
        w_extreme_d = r_extreme_q;

        unique case (r_state_q)
            IDLE: begin
                // A write in the same cycle takes priority over START.
                if (START && !WR_EN) begin
                    w_mode_d  = MODE;
                    w_count_d = '0;
                    w_flag_d  = 1'b0;
                    w_done_d  = 1'b0;
                    w_mar_d   = '0;
                    w_state_d = FETCH0;
                end
            end
            FETCH0: begin
                w_state_d = INIT;
            end
            INIT: begin
                w_extreme_d = w_rdata;
                w_temp_d    = w_rdata;
                w_mar_d     = c_addr_one;
                w_state_d   = FETCH;
            end
            FETCH: begin
                w_state_d = CMP;
            end
            CMP: begin
                unique case (r_mode_q)
                    MODE_PEAK: begin
                        if (w_diff_neg && r_flag_q) begin
                            w_count_d = r_count_q + c_addr_one;
                            w_flag_d  = 1'b0;
                        end else if (w_diff_pos) begin
                            w_flag_d = 1'b1;
                            if (w_rdata > r_extreme_q) begin
                                w_extreme_d = w_rdata;
                            end
                        end
                    end
                    MODE_VALLEY: begin
                        if (w_diff_pos && r_flag_q) begin
                            w_count_d = r_count_q + c_addr_one;
                            w_flag_d  = 1'b0;
                        end else if (w_diff_neg) begin
                            w_flag_d = 1'b1;
                            if (w_rdata < r_extreme_q) begin
                                w_extreme_d = w_rdata;
                            end
                        end
                    end
                    default: ;
                endcase
                w_temp_d = w_rdata;
                // Last address is all ones; no wrap back to sample 0.
                if (&r_mar_q) begin
                    // DONE is raised on entry to DONE_ST so that it becomes
                    // visible together with the final results.
                    w_done_d  = 1'b1;
                    w_state_d = DONE_ST;
                end else begin
                    w_mar_d   = r_mar_q + c_addr_one;
                    w_state_d = FETCH;
                end
            end
            DONE_ST: begin
                w_done_d  = 1'b1;
                w_state_d = HOLD;
            end
            HOLD: begin
                if (!START) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state_q   <= IDLE;
            r_mode_q    <= MODE_PEAK;
            r_flag_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_mar_q     <= '0;
            r_count_q   <= '0;
            r_temp_q    <= '0;
            r_extreme_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_mode_q    <= w_mode_d;
            r_flag_q    <= w_flag_d;
            r_done_q    <= w_done_d;
            r_mar_q     <= w_mar_d;
            r_count_q   <= w_count_d;
            r_temp_q    <= w_temp_d;
            r_extreme_q <= w_extreme_d;
        end
    end

    assign BUSY    = state_is_busy(r_state_q);
    assign DONE    = r_done_q;
    assign EXTREME = r_extreme_q;
    assign SIGN    = r_extreme_q[DATA_W-1];
    assign COUNT   = r_count_q;

endmodule : peak_scanner
`default_nettype wire

// File: tb/tb_peak_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_peak_scanner
// Description : Self-checking bench for peak_scanner (DEPTH = 8, DATA_W = 9).
//               Stimulus pushes hand-computed expected results into a
//               scoreboard queue; a monitor pops and compares on each DONE
//               rising edge, including the DONE latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peak_scanner;

    localparam int DATA_W = 9;
    localparam int ADDR_W = 3;

    logic              CLOCK = 1'b0;
    logic              RESET;
    logic              START;
    logic              MODE;
    logic              WR_EN;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              BUSY;
    logic              DONE;
    logic [DATA_W-1:0] EXTREME;
    logic              SIGN;
    logic [ADDR_W-1:0] COUNT;

    peak_scanner #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .START   (START),
        .MODE    (MODE),
        .WR_EN   (WR_EN),
        .WR_ADDR (WR_ADDR),
        .WR_DATA (WR_DATA),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .EXTREME (EXTREME),
        .SIGN    (SIGN),
        .COUNT   (COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct {
        int count;
        int ext;
        int done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare results whenever DONE rises.
    logic done_prev = 1'b0;
    exp_t mon_e;
    always @(negedge CLOCK) begin
        if (DONE && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("count",      int'(COUNT),            mon_e.count);
                check("extreme",    int'($signed(EXTREME)), mon_e.ext);
                check("sign",       int'(SIGN),             (mon_e.ext < 0) ? 1 : 0);
                check("done_cycle", cyc,                    mon_e.done_cyc);
            end
        end
        done_prev <= DONE;
    end

    task automatic load(input int v [8]);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK);
            WR_EN   = 1'b1;
            WR_ADDR = i[ADDR_W-1:0];
            WR_DATA = v[i][DATA_W-1:0];
        end
        @(negedge CLOCK);
        WR_EN = 1'b0;
    endtask

    // Issue one scan; edge 0 samples START, DONE expected after edge 16.
    task automatic scan(input logic m, input int ecount, input int eext,
                        input bit wr_busy, input bit hold);
        exp_t e;
        e.count = ecount;
        e.ext   = eext;
        @(negedge CLOCK);
        START = 1'b1;
        MODE  = m;
        @(posedge CLOCK);
        #1;
        e.done_cyc = cyc + 16;
        sb_q.push_back(e);
        check("busy_at_start", int'(BUSY), 1);
        check("done_cleared",  int'(DONE), 0);
        if (!hold) START = 1'b0;
        MODE = ~m;
        for (int i = 0; i < 40 && !DONE; i++) begin
            @(negedge CLOCK);
            if (wr_busy && i < 8) begin
                WR_EN   = 1'b1;
                WR_ADDR = i[ADDR_W-1:0];
                WR_DATA = 9'h1FF;
            end else begin
                WR_EN = 1'b0;
            end
        end
        WR_EN = 1'b0;
        check("done_seen", int'(DONE), 1);
        check("busy_off_at_done", int'(BUSY), 0);
        repeat (3) @(negedge CLOCK);
    endtask

    int d_a   [8] = '{50, 40, 0, -22, 0, -50, 75, 10};
    int d_alt [8] = '{-256, 255, -256, 255, -256, 255, -256, 255};
    int d_plt [8] = '{1, 3, 3, 1, 1, 3, 3, 3};
    int d_sev [8] = '{7, 7, 7, 7, 7, 7, 7, 7};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET   = 1'b1;
        START   = 1'b0;
        MODE    = 1'b0;
        WR_EN   = 1'b0;
        WR_ADDR = '0;
        WR_DATA = '0;
        repeat (3) @(negedge CLOCK);
        check("rst_busy",    int'(BUSY),    0);
        check("rst_done",    int'(DONE),    0);
        check("rst_extreme", int'(EXTREME), 0);
        check("rst_sign",    int'(SIGN),    0);
        check("rst_count",   int'(COUNT),   0);
        RESET = 1'b0;

        // Mixed data, peaks, START held through HOLD.
        load(d_a);
        scan(1'b0, 2, 75, 1'b0, 1'b1);
        check("hold_done", int'(DONE), 1);
        check("hold_busy", int'(BUSY), 0);
        @(negedge CLOCK);
        START = 1'b0;
        repeat (2) @(negedge CLOCK);
        check("idle_done_kept", int'(DONE), 1);

        // Valleys, with writes attempted while busy (must be ignored).
        scan(1'b1, 2, -50, 1'b1, 1'b0);
        // Rescan peaks: RAM must still hold the original data.
        scan(1'b0, 2, 75, 1'b0, 1'b0);

        // Reset in the middle of a scan.
        @(negedge CLOCK);
        START = 1'b1;
        MODE  = 1'b0;
        @(posedge CLOCK);
        #1;
        START = 1'b0;
        repeat (5) @(posedge CLOCK);
        #1;
        check("pre_reset_busy", int'(BUSY), 1);
        RESET = 1'b1;
        @(posedge CLOCK);
        #1;
        check("midrst_busy",    int'(BUSY),    0);
        check("midrst_done",    int'(DONE),    0);
        check("midrst_extreme", int'(EXTREME), 0);
        check("midrst_sign",    int'(SIGN),    0);
        check("midrst_count",   int'(COUNT),   0);
        RESET = 1'b0;
        scan(1'b1, 2, -50, 1'b0, 1'b0);

        // Full-range alternation: difference must not overflow.
        load(d_alt);
        scan(1'b0, 3, 255, 1'b0, 1'b0);

        // Plateaus count once.
        load(d_plt);
        scan(1'b0, 1, 3, 1'b0, 1'b0);

        // Flat data: no events.
        load(d_sev);
        scan(1'b0, 0, 7, 1'b0, 1'b0);
        scan(1'b1, 0, 7, 1'b0, 1'b0);

        repeat (3) @(negedge CLOCK);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_peak_scanner
`default_nettype wire
